// File: rtl/mode_counter_pkg.sv
// Shared encodings for the mode counter: mode selects and one-shot FSM states.
package mode_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mode_counter_tick_prescaler.sv
// Step prescaler: emits one tick per prescale+1 enabled cycles; clear restarts the period.
module tick_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = enable && (pre_cnt_q == prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear || tick) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with wrap, saturate and one-shot modes, prescaled stepping and
// registered tc/sat/busy status.
//
// state   | meaning
// ST_IDLE | one-shot not armed; count holds
// ST_RUN  | one-shot run in progress; busy=1
// ST_DONE | one-shot reached its bound; count holds
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sat,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             is_oneshot;
  logic             start_os;
  logic             leaving;
  logic             boundary;
  logic [WIDTH-1:0] count_next;

  assign is_oneshot = (mode == MODE_ONESHOT);
  assign start_os   = start && is_oneshot;
  // The cycle that drops out of one-shot only parks the FSM; no step is applied.
  assign leaving    = !is_oneshot && (state_q != ST_IDLE);
  assign boundary   = up_down ? (count_q >= limit) : (count_q == '0);
  assign count_next = up_down ? (count_q + CNT_ONE) : (count_q - CNT_ONE);

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (load_valid || start_os),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    sat_d   = sat_q;
    state_d = is_oneshot ? state_q : ST_IDLE;

    if (load_valid) begin
      count_d = (load_value > limit) ? limit : load_value;
      sat_d   = 1'b0;
    end else if (start_os) begin
      count_d = up_down ? '0 : limit;
      state_d = ST_RUN;
    end else if (tick && !leaving) begin
      case (mode)
        MODE_SAT: begin
          if (boundary) begin
            count_d = up_down ? limit : '0;
            tc_d    = !sat_q;
            sat_d   = 1'b1;
          end else begin
            count_d = count_next;
            sat_d   = 1'b0;
          end
        end
        MODE_ONESHOT: begin
          if (state_q == ST_RUN) begin
            if (boundary) begin
              count_d = up_down ? limit : '0;
              tc_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              count_d = count_next;
            end
          end
        end
        default: begin
          if (boundary) begin
            count_d = up_down ? '0 : limit;
            tc_d    = 1'b1;
          end else begin
            count_d = count_next;
          end
        end
      endcase
    end

    if (mode != MODE_SAT) begin
      sat_d = 1'b0;
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign sat   = sat_q;
  assign busy  = busy_q;

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_W, default 4, prescaler width in bits (legal range 1..16).
REQ-003 The block SHALL have port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port enable  input  1  counting enable, which qualifies prescaler advance.
REQ-006 The block SHALL have port load_valid  input  1  load strobe, honoured regardless of enable.
REQ-007 The block SHALL have port load_value  input  WIDTH  value to load.
REQ-008 The block SHALL have port limit  input  WIDTH  upper bound, giving a count range of 0..limit.
REQ-009 The block SHALL have port up_down  input  1  direction: 1 = up, 0 = down.
REQ-010 The block SHALL have port mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-011 The block SHALL have port prescale  input  PRE_W  step period: one step per prescale+1 enabled cycles.
REQ-012 The block SHALL have port start  input  1  one-shot arm strobe, ignored in modes other than one-shot.
REQ-013 The block SHALL have port count  output  WIDTH  registered count value.
REQ-014 The block SHALL have port tc  output  1  registered terminal-count pulse, high for one cycle.
REQ-015 The block SHALL have port sat  output  1  registered level: saturate mode is blocked at a bound.
REQ-016 The block SHALL have port busy  output  1  registered level: one-shot run is in progress.

Function
REQ-017 Update priority SHALL be reset, then load_valid, then start, then step.
REQ-018 On load_valid the next-cycle count SHALL be min(load_value, limit), the prescaler SHALL clear to 0, sat SHALL clear, and tc SHALL stay 0.
REQ-019 The prescaler SHALL advance only when enable=1; a step SHALL occur when pre_cnt==prescale, after which pre_cnt SHALL clear to 0.
REQ-020 With enable=0, count and pre_cnt SHALL hold; prescale=0 SHALL give one step per enabled cycle.
REQ-021 An up-step with count<limit SHALL increment count, and a down-step with count>0 SHALL decrement count.
REQ-022 A boundary step is an up-step with count>=limit or a down-step with count==0; tc SHALL be 1 in the cycle after every boundary step, except as REQ-024 specifies.
REQ-023 In wrap mode, an up boundary step SHALL set count to 0, and a down boundary step SHALL set count to limit.
REQ-024 In saturate mode a boundary step SHALL set count to limit (up) or hold 0 (down) and set sat=1; tc SHALL pulse only on the first blocked step; any successful step or load SHALL clear sat.
REQ-025 The one-shot FSM SHALL have the states IDLE, RUN and DONE; busy SHALL be 1 only in RUN.
REQ-026 In IDLE and DONE, count SHALL hold; in the cycle after start, count SHALL be 0 (up) or limit (down), the prescaler SHALL clear, and the FSM SHALL be in RUN.
REQ-027 In RUN, steps SHALL follow REQ-021; a boundary step SHALL leave count at the bound, pulse tc and move the FSM to DONE.
REQ-028 A start during RUN SHALL restart the run per REQ-026.
REQ-029 If mode leaves one-shot, the FSM SHALL go to IDLE on the next cycle and count SHALL be unchanged.
REQ-030 A load_valid during RUN SHALL load the count and SHALL NOT change the FSM state.
REQ-031 With limit=0, count SHALL stay 0 and every step SHALL be a boundary step (in wrap mode, tc pulses once per step).
REQ-032 Count arithmetic SHALL never wrap modulo 2^WIDTH; if limit falls below count, the next up-step SHALL be a boundary step.
REQ-033 A direction change SHALL take effect on the next step, with no lost or extra step.

Reset
REQ-034 In any cycle with reset=1, the next state SHALL be count=0, pre_cnt=0, tc=0, sat=0, busy=0 and FSM=IDLE.
REQ-035 Reset SHALL override load_valid, start and enable in the same cycle, including reset asserted mid-run.

Structure
REQ-036 The package mode_counter_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state enumeration.
REQ-037 The prescaler SHALL be the sub-module tick_prescaler (parameter PRE_W; inputs clk, reset, enable, clear, prescale; output tick).
REQ-038 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Verification
REQ-039 Wrap test: WIDTH=8, limit=5, up, prescale=0, enable=1 -> count 0,1,2,3,4,5,0; tc=1 in the cycle count returns to 0.
REQ-040 Saturate test: limit=3, down, load 2 -> count 2,1,0,0,0; tc pulses once; sat=1 from the first blocked step; a load of 2 then clears sat.
REQ-041 One-shot test: mode=10, limit=4, prescale=1, start -> busy=1, count 0..4 stepping every 2 cycles; then tc pulse, busy=0, count holds 4; a second start restarts from 0.
REQ-042 Load test: load_value=200 with limit=10 -> count=10; load_valid with enable=0 still loads.
REQ-043 Reset test: reset asserted mid-run together with load_valid and start -> next cycle all outputs 0 and FSM=IDLE.
REQ-044 Boundary test: limit lowered to 2 while count=7 in up wrap mode -> next step gives count=0 and a tc pulse; limit=0 -> tc every step.
